// File: rtl/cpu_ram_arbiter_pkg.sv
// Shared types and constants for the two-master cpu_ram arbiter.
package cpu_ram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    function automatic logic is_read(input logic [3:0] wstrb);
        return (wstrb == 4'b0000);
    endfunction

endpackage

// File: rtl/cpu_ram_arbiter_if.sv
// Held-valid / pulse-valid memory bus used on both the master and the RAM side of the arbiter.
interface cpu_ram_arbiter_if #(
    parameter int SIZE = 13
);
    logic            valid;
    logic [SIZE+1:0] addr;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic [31:0]     rdata;
    logic            ready;

    modport master (output valid, addr, wdata, wstrb, input rdata, ready);
    modport slave  (input valid, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/cpu_ram_arbiter_rr_arbiter2.sv
// Two-way winner select: round-robin on ties, or m0 always wins ties when PRIO_FIXED is set.
module rr_arbiter2
    import cpu_ram_arbiter_pkg::*;
#(
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       last_m1_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = GNT_NONE;
        if (req0_i && req1_i) begin
            gnt_o = (PRIO_FIXED || last_m1_i) ? GNT_M0 : GNT_M1;
        end else if (req0_i) begin
            gnt_o = GNT_M0;
        end else if (req1_i) begin
            gnt_o = GNT_M1;
        end
    end

endmodule

// File: rtl/cpu_ram_arbiter.sv
// Shares one cpu_ram between two held-valid masters, one RAM transaction outstanding at a time.
// States: IDLE arbitrate/latch | REQ ram_valid pulse | WAIT await ram_ready | DONE ready pulse to owner
module cpu_ram_arbiter
    import cpu_ram_arbiter_pkg::*;
#(
    parameter int SIZE       = 13,
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic                clk,
    input  logic                resetn,
    cpu_ram_arbiter_if.slave    m0,
    cpu_ram_arbiter_if.slave    m1,
    cpu_ram_arbiter_if.master   ram,
    output logic [31:0]         m_rdata,
    output logic [1:0]          grant,
    output logic                busy
);

    arb_state_e      state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic            last_m1_q, last_m1_d;
    logic [SIZE+1:0] addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [1:0]      win;

    rr_arbiter2 #(.PRIO_FIXED(PRIO_FIXED)) u_arb (
        .req0_i    (m0.valid),
        .req1_i    (m1.valid),
        .last_m1_i (last_m1_q),
        .gnt_o     (win)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            grant_q   <= GNT_NONE;
            last_m1_q <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_m1_q <= last_m1_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_m1_d = last_m1_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (win != GNT_NONE) begin
                    grant_d   = win;
                    last_m1_d = (win == GNT_M1);
                    state_d   = REQ;
                    if (win == GNT_M1) begin
                        addr_d  = m1.addr;
                        wdata_d = m1.wdata;
                        wstrb_d = m1.wstrb;
                    end else begin
                        addr_d  = m0.addr;
                        wdata_d = m0.wdata;
                        wstrb_d = m0.wstrb;
                    end
                end
            end
            // a zero-wait RAM may already answer during the request cycle
            REQ, WAIT: begin
                if (ram.ready) begin
                    if (is_read(wstrb_q)) begin
                        rdata_d = ram.rdata;
                    end
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = GNT_NONE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ram.valid = (state_q == REQ);
    assign ram.addr  = addr_q;
    assign ram.wdata = wdata_q;
    assign ram.wstrb = wstrb_q;

    assign m0.ready  = (state_q == DONE) && (grant_q == GNT_M0);
    assign m1.ready  = (state_q == DONE) && (grant_q == GNT_M1);
    assign m0.rdata  = rdata_q;
    assign m1.rdata  = rdata_q;

    assign m_rdata   = rdata_q;
    assign grant     = grant_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cpu_ram_arbiter.sv
// Bench: two arbiters (round-robin and fixed priority) each in front of a behavioural RAM.
`timescale 1ns/1ps
module tb_cpu_ram_arbiter;
    import cpu_ram_arbiter_pkg::*;

    localparam int SIZE = 13;

    typedef struct {
        int          id;
        bit          rd;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    cpu_ram_arbiter_if #(.SIZE(SIZE)) a_m0 ();
    cpu_ram_arbiter_if #(.SIZE(SIZE)) a_m1 ();
    cpu_ram_arbiter_if #(.SIZE(SIZE)) a_ram ();
    cpu_ram_arbiter_if #(.SIZE(SIZE)) b_m0 ();
    cpu_ram_arbiter_if #(.SIZE(SIZE)) b_m1 ();
    cpu_ram_arbiter_if #(.SIZE(SIZE)) b_ram ();

    logic [31:0] a_rdata, b_rdata;
    logic [1:0]  a_grant, b_grant;
    logic        a_busy, b_busy;

    cpu_ram_arbiter #(.SIZE(SIZE), .PRIO_FIXED(1'b0)) u_dut_a (
        .clk(clk), .resetn(resetn), .m0(a_m0), .m1(a_m1), .ram(a_ram),
        .m_rdata(a_rdata), .grant(a_grant), .busy(a_busy)
    );

    cpu_ram_arbiter #(.SIZE(SIZE), .PRIO_FIXED(1'b1)) u_dut_b (
        .clk(clk), .resetn(resetn), .m0(b_m0), .m1(b_m1), .ram(b_ram),
        .m_rdata(b_rdata), .grant(b_grant), .busy(b_busy)
    );

    int total = 0;
    int bad   = 0;
    exp_t a_q[$];
    exp_t b_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
        end
    endtask

    // behavioural cpu_ram: acts on the valid pulse, ready after ram_lat cycles
    logic [31:0] mem [0:(1<<SIZE)-1];
    int ram_lat = 1;
    int a_cnt;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_ram.ready <= 1'b0;
            a_ram.rdata <= '0;
            a_cnt       <= 0;
        end else begin
            a_ram.ready <= 1'b0;
            if (a_ram.valid) begin
                for (int b = 0; b < 4; b++)
                    if (a_ram.wstrb[b]) mem[a_ram.addr[SIZE+1:2]][8*b +: 8] <= a_ram.wdata[8*b +: 8];
                a_ram.rdata <= mem[a_ram.addr[SIZE+1:2]];
                if (ram_lat <= 1) a_ram.ready <= 1'b1;
                else a_cnt <= ram_lat - 1;
            end else if (a_cnt > 0) begin
                a_cnt <= a_cnt - 1;
                if (a_cnt == 1) a_ram.ready <= 1'b1;
            end
        end
    end

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            b_ram.ready <= 1'b0;
            b_ram.rdata <= '0;
        end else begin
            b_ram.ready <= b_ram.valid;
        end
    end

    // completion monitors: pop the scoreboard on every ready pulse
    int   a_vrun = 0, b_vrun = 0;
    logic a_p0 = 0, a_p1 = 0, b_p0 = 0, b_p1 = 0;
    exp_t ea, eb;

    always @(negedge clk) begin
        if (!resetn) begin
            a_vrun = 0;
        end else begin
            if (a_ram.valid) a_vrun++;
            else begin
                if (a_vrun != 0) chk("a_ram_valid_width", a_vrun, 1);
                a_vrun = 0;
            end
            if (a_m0.ready) chk("a_m0_ready_width", a_p0, 0);
            if (a_m1.ready) chk("a_m1_ready_width", a_p1, 0);
            if (a_m0.ready || a_m1.ready) begin
                chk("a_both_ready", a_m0.ready & a_m1.ready, 0);
                chk("a_sb_pending", a_q.size() > 0, 1);
                if (a_q.size() > 0) begin
                    ea = a_q.pop_front();
                    chk("a_order", a_m1.ready ? 1 : 0, ea.id);
                    if (ea.rd) chk("a_rdata", a_rdata, ea.data);
                end
            end
        end
        a_p0 = a_m0.ready;
        a_p1 = a_m1.ready;
    end

    always @(negedge clk) begin
        if (!resetn) begin
            b_vrun = 0;
        end else begin
            if (b_ram.valid) b_vrun++;
            else begin
                if (b_vrun != 0) chk("b_ram_valid_width", b_vrun, 1);
                b_vrun = 0;
            end
            if (b_m0.ready) chk("b_m0_ready_width", b_p0, 0);
            if (b_m1.ready) chk("b_m1_ready_width", b_p1, 0);
            if (b_m0.ready || b_m1.ready) begin
                chk("b_both_ready", b_m0.ready & b_m1.ready, 0);
                chk("b_sb_pending", b_q.size() > 0, 1);
                if (b_q.size() > 0) begin
                    eb = b_q.pop_front();
                    chk("b_order", b_m1.ready ? 1 : 0, eb.id);
                end
            end
        end
        b_p0 = b_m0.ready;
        b_p1 = b_m1.ready;
    end

    function automatic logic [SIZE+1:0] wa(input int w);
        logic [SIZE+1:0] r;
        r = {w[SIZE-1:0], 2'b00};
        return r;
    endfunction

    function automatic void push_exp(input int inst, input int id, input bit rd, input logic [31:0] d);
        exp_t e;
        e.id = id; e.rd = rd; e.data = d;
        if (inst == 0) a_q.push_back(e);
        else b_q.push_back(e);
    endfunction

    task automatic drive(input int inst, input int m, input logic v, input logic [SIZE+1:0] ad,
                         input logic [31:0] wd, input logic [3:0] ws);
        if (inst == 0 && m == 0) begin
            a_m0.valid = v; a_m0.addr = ad; a_m0.wdata = wd; a_m0.wstrb = ws;
        end else if (inst == 0) begin
            a_m1.valid = v; a_m1.addr = ad; a_m1.wdata = wd; a_m1.wstrb = ws;
        end else if (m == 0) begin
            b_m0.valid = v; b_m0.addr = ad; b_m0.wdata = wd; b_m0.wstrb = ws;
        end else begin
            b_m1.valid = v; b_m1.addr = ad; b_m1.wdata = wd; b_m1.wstrb = ws;
        end
    endtask

    function automatic logic rdy(input int inst, input int m);
        if (inst == 0) return (m == 0) ? a_m0.ready : a_m1.ready;
        return (m == 0) ? b_m0.ready : b_m1.ready;
    endfunction

    // called just after a posedge; returns just after the edge on which ready was seen
    task automatic txn(input int inst, input int m, input int word, input logic [31:0] wd,
                       input logic [3:0] ws, input bit push, input logic [31:0] exp_rd,
                       output int lat);
        logic got;
        if (push) push_exp(inst, m, ws == 4'b0000, exp_rd);
        drive(inst, m, 1'b1, wa(word), wd, ws);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 60) begin
            @(negedge clk);
            lat++;
            got = rdy(inst, m);
        end
        chk("txn_completed", got, 1);
        @(posedge clk);
        #1;
        drive(inst, m, 1'b0, '0, '0, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, lat0, lat1;
        for (int i = 0; i < 4; i++) drive(i / 2, i % 2, 1'b0, '0, '0, '0);
        resetn = 1'b0;

        // reset values
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_ram_valid", a_ram.valid, 0);
        chk("rst_m0_ready", a_m0.ready, 0);
        chk("rst_m1_ready", a_m1.ready, 0);
        chk("rst_grant", a_grant, GNT_NONE);
        chk("rst_busy", a_busy, 0);
        chk("rst_m_rdata", a_rdata, 0);
        chk("rst_b_grant", b_grant, GNT_NONE);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // both masters held valid, round-robin: m0, m1, m0, m1
        push_exp(0, 0, 0, 0);
        push_exp(0, 1, 0, 0);
        push_exp(0, 0, 1, 32'h0A0A_0020);
        push_exp(0, 1, 1, 32'h0B0B_0021);
        fork
            begin
                txn(0, 0, 20, 32'h0A0A_0020, 4'hF, 0, 0, lat0);
                txn(0, 0, 20, 32'h0, 4'h0, 0, 0, lat0);
            end
            begin
                txn(0, 1, 21, 32'h0B0B_0021, 4'hF, 0, 0, lat1);
                txn(0, 1, 21, 32'h0, 4'h0, 0, 0, lat1);
            end
        join
        chk("rr_rdata_last", a_rdata, 32'h0B0B_0021);

        // fixed priority: m0 served three times before m1
        push_exp(1, 0, 0, 0);
        push_exp(1, 0, 0, 0);
        push_exp(1, 0, 0, 0);
        push_exp(1, 1, 0, 0);
        fork
            begin
                txn(1, 0, 1, 32'h1, 4'hF, 0, 0, lat0);
                txn(1, 0, 2, 32'h2, 4'hF, 0, 0, lat0);
                txn(1, 0, 3, 32'h3, 4'hF, 0, 0, lat0);
            end
            txn(1, 1, 4, 32'h4, 4'hF, 0, 0, lat1);
        join
        chk("prio_m1_wait", lat1, 16);

        // m0 write then read of word 3, latency with a 1-cycle RAM
        txn(0, 0, 3, 32'hDEAD_BEEF, 4'hF, 1, 0, lat);
        chk("lat_write", lat, 4);
        txn(0, 0, 3, 32'h0, 4'h0, 1, 32'hDEAD_BEEF, lat);
        chk("lat_read", lat, 4);
        chk("rdata_word3", a_rdata, 32'hDEAD_BEEF);

        // byte-lane merge from both masters into word 7
        mem[7] = 32'hAABB_CCDD;
        txn(0, 1, 7, 32'h0000_0011, 4'b0001, 1, 0, lat);
        txn(0, 0, 7, 32'h0033_0000, 4'b0100, 1, 0, lat);
        txn(0, 0, 7, 32'h0, 4'h0, 1, 32'hAA33_CC11, lat);
        chk("merge_word7", a_rdata, 32'hAA33_CC11);
        txn(0, 1, 9, 32'h5555_5555, 4'hF, 1, 0, lat);
        chk("rdata_hold_after_write", a_rdata, 32'hAA33_CC11);

        // reset while waiting on a slow RAM
        ram_lat = 5;
        drive(0, 0, 1'b1, wa(3), 32'h0, 4'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #2;
        chk("wait_busy", a_busy, 1);
        chk("wait_grant", a_grant, GNT_M0);
        chk("wait_ram_valid", a_ram.valid, 0);
        resetn = 1'b0;
        #1;
        chk("arst_ram_valid", a_ram.valid, 0);
        chk("arst_m0_ready", a_m0.ready, 0);
        chk("arst_grant", a_grant, GNT_NONE);
        chk("arst_busy", a_busy, 0);
        chk("arst_m_rdata", a_rdata, 0);
        chk("arst_ram_addr", a_ram.addr, 0);
        drive(0, 0, 1'b0, '0, '0, '0);
        repeat (2) begin
            @(negedge clk);
            chk("arst_no_ready", a_m0.ready | a_m1.ready, 0);
        end
        resetn = 1'b1;
        ram_lat = 1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_ready", a_m0.ready | a_m1.ready, 0);
        end
        @(posedge clk);
        #1;
        txn(0, 1, 3, 32'h0, 4'h0, 1, 32'hDEAD_BEEF, lat);
        chk("post_rst_read", a_rdata, 32'hDEAD_BEEF);

        repeat (3) @(posedge clk);
        chk("a_sb_empty", a_q.size(), 0);
        chk("b_sb_empty", b_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
